// File: rtl/uart_matrix_cfg.sv
// Configuration sequencer for uart_matrix: bulk-loads the default routing table after reset,
// then applies routing updates parsed from a UART byte stream (A5, addr, mask bytes LSB first).
module uart_matrix_cfg #(
    parameter int unsigned                  INPUTS  = 2,
    parameter int unsigned                  OUTPUTS = 3,
    parameter logic [INPUTS*OUTPUTS-1:0]    INIT    = '1,
    parameter int unsigned                  TIMEOUT = 1000,
    localparam int unsigned                 AW      = (INPUTS > 1) ? $clog2(INPUTS) : 1,
    localparam int unsigned                 NB      = (OUTPUTS + 7) / 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [7:0]         cmd_data,
    input  logic               cmd_cke,
    output logic [OUTPUTS-1:0] lut_data,
    output logic [AW-1:0]      lut_addr,
    output logic               lut_cke,
    output logic               busy,
    output logic               err
);

    localparam int unsigned BW = (NB > 1) ? $clog2(NB) : 1;
    localparam int unsigned GW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [7:0]  SyncByte = 8'hA5;
    localparam logic [7:0]  ReloadAddr = 8'hFF;

    typedef enum logic [2:0] {StLoad, StSync, StAddr, StMask, StCommit} state_e;

    state_e              state_q, state_d;
    logic [AW-1:0]       load_idx_q, load_idx_d;
    logic [7:0]          addr_q, addr_d;
    logic [NB*8-1:0]     mask_q, mask_d;
    logic [BW-1:0]       byte_idx_q, byte_idx_d;
    logic [GW-1:0]       gap_q, gap_d;
    logic [OUTPUTS-1:0]  lut_data_q, lut_data_d;
    logic [AW-1:0]       lut_addr_q, lut_addr_d;
    logic                lut_cke_q, lut_cke_d;
    logic                busy_q, busy_d;
    logic                err_q, err_d;

    logic last_load, last_byte, addr_ok, timed_out;

    assign last_load = (load_idx_q == AW'(INPUTS - 1));
    assign last_byte = (byte_idx_q == BW'(NB - 1));
    assign addr_ok   = ({24'd0, addr_q} < 32'(INPUTS));
    assign timed_out = (gap_q == GW'(TIMEOUT));

    always_comb begin
        state_d    = state_q;
        load_idx_d = load_idx_q;
        addr_d     = addr_q;
        mask_d     = mask_q;
        byte_idx_d = byte_idx_q;
        gap_d      = '0;
        lut_data_d = lut_data_q;
        lut_addr_d = lut_addr_q;
        lut_cke_d  = 1'b0;
        busy_d     = (state_q == StLoad);
        err_d      = 1'b0;

        unique case (state_q)
            StLoad: begin
                lut_cke_d  = 1'b1;
                lut_addr_d = load_idx_q;
                lut_data_d = INIT[int'(load_idx_q) * OUTPUTS +: OUTPUTS];
                load_idx_d = load_idx_q + 1'b1;
                err_d      = cmd_cke;
                if (last_load) begin
                    load_idx_d = '0;
                    state_d    = StSync;
                end
            end
            StSync: begin
                // busy_q still high here means the last load write is on the port this cycle
                if (cmd_cke && busy_q) begin
                    err_d = 1'b1;
                end else if (cmd_cke && cmd_data == SyncByte) begin
                    state_d = StAddr;
                end
            end
            StAddr: begin
                if (timed_out) begin
                    err_d   = 1'b1;
                    state_d = StSync;
                end else if (cmd_cke) begin
                    addr_d     = cmd_data;
                    byte_idx_d = '0;
                    state_d    = StMask;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            StMask: begin
                if (timed_out) begin
                    err_d   = 1'b1;
                    state_d = StSync;
                end else if (cmd_cke) begin
                    mask_d[8*byte_idx_q +: 8] = cmd_data;
                    byte_idx_d = byte_idx_q + 1'b1;
                    if (last_byte) begin
                        state_d = StCommit;
                        // Write issued on entry to COMMIT to meet the one-cycle write latency
                        if (addr_ok) begin
                            lut_cke_d  = 1'b1;
                            lut_addr_d = AW'(addr_q);
                            lut_data_d = mask_d[OUTPUTS-1:0];
                        end
                    end
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            StCommit: begin
                state_d = StSync;
                if (addr_q == ReloadAddr) begin
                    state_d    = StLoad;
                    load_idx_d = '0;
                    err_d      = cmd_cke;
                end else begin
                    err_d = !addr_ok;
                    if (cmd_cke && cmd_data == SyncByte) begin
                        state_d = StAddr;
                    end
                end
            end
            default: state_d = StLoad;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StLoad;
            load_idx_q <= '0;
            addr_q     <= '0;
            mask_q     <= '0;
            byte_idx_q <= '0;
            gap_q      <= '0;
            lut_data_q <= '0;
            lut_addr_q <= '0;
            lut_cke_q  <= 1'b0;
            busy_q     <= 1'b1;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            load_idx_q <= load_idx_d;
            addr_q     <= addr_d;
            mask_q     <= mask_d;
            byte_idx_q <= byte_idx_d;
            gap_q      <= gap_d;
            lut_data_q <= lut_data_d;
            lut_addr_q <= lut_addr_d;
            lut_cke_q  <= lut_cke_d;
            busy_q     <= busy_d;
            err_q      <= err_d;
        end
    end

    assign lut_data = lut_data_q;
    assign lut_addr = lut_addr_q;
    assign lut_cke  = lut_cke_q;
    assign busy     = busy_q;
    assign err      = err_q;

endmodule

// File: tb/tb_uart_matrix_cfg.sv
// Bench for uart_matrix_cfg: two instances (3-bit and 10-bit masks) checked every cycle against a
// frame-level byte-stream model, plus literal checks on the logged LUT writes and error pulses.
module tb_uart_matrix_cfg;

    localparam int TO = 20;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [7:0] data_a, data_b;
    logic       cke_a, cke_b;

    logic [2:0] lut_data_a;
    logic [0:0] lut_addr_a;
    logic       lut_cke_a, busy_a, err_a;
    logic [9:0] lut_data_b;
    logic [1:0] lut_addr_b;
    logic       lut_cke_b, busy_b, err_b;

    uart_matrix_cfg #(
        .INPUTS(2), .OUTPUTS(3), .INIT(6'b001_111), .TIMEOUT(TO)
    ) dut_a (
        .clk(clk), .rst(rst), .cmd_data(data_a), .cmd_cke(cke_a),
        .lut_data(lut_data_a), .lut_addr(lut_addr_a), .lut_cke(lut_cke_a),
        .busy(busy_a), .err(err_a)
    );

    uart_matrix_cfg #(
        .INPUTS(3), .OUTPUTS(10), .INIT({10'h2AA, 10'h155, 10'h00F}), .TIMEOUT(TO)
    ) dut_b (
        .clk(clk), .rst(rst), .cmd_data(data_b), .cmd_cke(cke_b),
        .lut_data(lut_data_b), .lut_addr(lut_addr_b), .lut_cke(lut_cke_b),
        .busy(busy_b), .err(err_b)
    );

    int total = 0;
    int bad   = 0;

    // ---------------- behavioural model ----------------
    int n_in[2]        = '{2, 3};
    int n_out[2]       = '{3, 10};
    int nb[2]          = '{1, 2};
    int init_tbl[2][3] = '{'{7, 1, 0}, '{'h00F, 'h155, 'h2AA}};

    logic        cke_e[2], busy_e[2], err_e[2];
    logic [31:0] addr_e[2], data_e[2];
    bit          loading[2];
    int          load_pos[2];
    int          fbuf[2][4];
    int          flen[2];
    bit          commit_pend[2];
    int          commit_addr[2];
    int          last_edge[2];
    int          cyc = 0;

    task automatic step(input int d, input logic r, input logic k, input logic [7:0] b);
        logic busy_vis;
        int   m;
        busy_vis = busy_e[d];
        err_e[d] = 1'b0;
        cke_e[d] = 1'b0;
        if (r) begin
            loading[d] = 1; load_pos[d] = 0; flen[d] = 0; commit_pend[d] = 0;
            busy_e[d] = 1'b1; addr_e[d] = 0; data_e[d] = 0;
            return;
        end
        if (loading[d]) begin
            cke_e[d]  = 1'b1;
            addr_e[d] = load_pos[d];
            data_e[d] = init_tbl[d][load_pos[d]];
            load_pos[d]++;
            if (load_pos[d] == n_in[d]) loading[d] = 0;
            busy_e[d] = 1'b1;
            err_e[d]  = k;
            return;
        end
        busy_e[d] = 1'b0;
        if (busy_vis) begin
            err_e[d] = k;
            return;
        end
        if (commit_pend[d]) begin
            commit_pend[d] = 0;
            if (commit_addr[d] == 255) begin
                loading[d] = 1; load_pos[d] = 0;
                err_e[d] = k;
                return;
            end
            if (commit_addr[d] >= n_in[d]) err_e[d] = 1'b1;
        end
        if (flen[d] == 0) begin
            if (k && b == 8'hA5) begin
                fbuf[d][0] = b; flen[d] = 1; last_edge[d] = cyc;
            end
        end else if (cyc - last_edge[d] > TO) begin
            err_e[d] = 1'b1;
            flen[d]  = 0;
        end else if (k) begin
            fbuf[d][flen[d]] = b;
            flen[d]++;
            last_edge[d] = cyc;
            if (flen[d] == 2 + nb[d]) begin
                m = 0;
                for (int j = 0; j < nb[d]; j++) m = m | (fbuf[d][2+j] << (8 * j));
                m = m & ((1 << n_out[d]) - 1);
                if (fbuf[d][1] < n_in[d]) begin
                    cke_e[d] = 1'b1; addr_e[d] = fbuf[d][1]; data_e[d] = m;
                end
                commit_pend[d] = 1;
                commit_addr[d] = fbuf[d][1];
                flen[d] = 0;
            end
        end
    endtask

    always @(posedge clk) begin
        cyc++;
        step(0, rst, cke_a, data_a);
        step(1, rst, cke_b, data_b);
    end

    // ---------------- per-cycle compare and logs ----------------
    bit          chk_en = 0;
    logic [31:0] wr_a[$];
    logic [31:0] wr_b[$];
    int          errs_a = 0, errs_b = 0;

    always @(negedge clk) begin
        if (chk_en) begin
            total++;
            if (lut_cke_a !== cke_e[0] || {31'd0, lut_addr_a} !== addr_e[0] ||
                {29'd0, lut_data_a} !== data_e[0] || busy_a !== busy_e[0] || err_a !== err_e[0]) begin
                bad++;
                $display("FAIL cycle%0d dut_a: got cke=%b addr=%0d data=%h busy=%b err=%b want cke=%b addr=%0d data=%h busy=%b err=%b",
                         cyc, lut_cke_a, lut_addr_a, lut_data_a, busy_a, err_a,
                         cke_e[0], addr_e[0], data_e[0], busy_e[0], err_e[0]);
            end
            total++;
            if (lut_cke_b !== cke_e[1] || {30'd0, lut_addr_b} !== addr_e[1] ||
                {22'd0, lut_data_b} !== data_e[1] || busy_b !== busy_e[1] || err_b !== err_e[1]) begin
                bad++;
                $display("FAIL cycle%0d dut_b: got cke=%b addr=%0d data=%h busy=%b err=%b want cke=%b addr=%0d data=%h busy=%b err=%b",
                         cyc, lut_cke_b, lut_addr_b, lut_data_b, busy_b, err_b,
                         cke_e[1], addr_e[1], data_e[1], busy_e[1], err_e[1]);
            end
            if (lut_cke_a === 1'b1) wr_a.push_back({28'd0, lut_addr_a, lut_data_a});
            if (lut_cke_b === 1'b1) wr_b.push_back({20'd0, lut_addr_b, lut_data_b});
            if (err_a === 1'b1) errs_a++;
            if (err_b === 1'b1) errs_b++;
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    function automatic logic [31:0] wr_at(input int d, input int i);
        if (d == 0) return (i < wr_a.size()) ? wr_a[i] : 32'hDEAD;
        return (i < wr_b.size()) ? wr_b[i] : 32'hDEAD;
    endfunction

    // ---------------- stimulus ----------------
    task automatic send(input int d, input logic [7:0] b);
        if (d == 0) begin data_a = b; cke_a = 1'b1; end
        else begin data_b = b; cke_b = 1'b1; end
        @(posedge clk);
        #1;
        cke_a = 1'b0;
        cke_b = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; cke_a = 1'b0; cke_b = 1'b0; data_a = 8'h00; data_b = 8'h00;
        @(posedge clk);
        #1;
        chk_en = 1;
        idle(1);
        rst = 1'b0;
        idle(5);
        // default load
        check("load_a_count", wr_a.size(), 2);
        check("load_a_0", wr_at(0, 0), 32'h7);
        check("load_a_1", wr_at(0, 1), 32'h9);
        check("load_b_0", wr_at(1, 0), 32'h00F);
        check("load_b_1", wr_at(1, 1), 32'h555);
        check("load_b_2", wr_at(1, 2), 32'hAAA);
        check("load_busy_low", {31'd0, busy_a}, 0);
        check("load_no_err", errs_a, 0);

        // runtime update
        send(0, 8'hA5); send(0, 8'h01); send(0, 8'h05);
        idle(3);
        check("upd_count", wr_a.size(), 3);
        check("upd_value", wr_at(0, 2), 32'hD);
        check("upd_no_err", errs_a, 0);

        // junk byte, then bad address
        send(0, 8'h3C);
        idle(2);
        send(0, 8'hA5); send(0, 8'h07); send(0, 8'h02);
        idle(3);
        check("badaddr_err", errs_a, 1);
        check("badaddr_nowrite", wr_a.size(), 3);

        // timeout, byte on the timeout cycle discarded
        send(0, 8'hA5); send(0, 8'h01);
        idle(TO);
        send(0, 8'h02);
        idle(2);
        check("timeout_err", errs_a, 2);
        check("timeout_nowrite", wr_a.size(), 3);
        send(0, 8'hA5); send(0, 8'h00); send(0, 8'h06);
        idle(3);
        check("after_to_value", wr_at(0, 3), 32'h6);

        // largest allowed gap still completes the frame
        send(0, 8'hA5); send(0, 8'h01);
        idle(TO - 1);
        send(0, 8'h03);
        idle(3);
        check("gap_edge_value", wr_at(0, 4), 32'hB);
        check("gap_edge_no_err", errs_a, 2);

        // reload via address FF, with a byte dropped during LOAD
        send(0, 8'hA5); send(0, 8'hFF); send(0, 8'h00);
        idle(1);
        send(0, 8'hA5);
        idle(5);
        check("reload_err", errs_a, 3);
        check("reload_count", wr_a.size(), 7);
        check("reload_0", wr_at(0, 5), 32'h7);
        check("reload_1", wr_at(0, 6), 32'h9);
        send(0, 8'hA5); send(0, 8'h00); send(0, 8'h03);
        idle(3);
        check("post_reload", wr_at(0, 7), 32'h3);

        // reset mid-frame: stale frame never commits
        send(0, 8'hA5); send(0, 8'h01);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        idle(4);
        send(0, 8'h05);
        idle(3);
        check("rst_count", wr_a.size(), 10);
        check("rst_0", wr_at(0, 8), 32'h7);
        check("rst_1", wr_at(0, 9), 32'h9);
        check("rst_no_err", errs_a, 3);

        // wide mask
        send(1, 8'hA5); send(1, 8'h00); send(1, 8'hFF); send(1, 8'hFF);
        idle(3);
        send(1, 8'hA5); send(1, 8'h02); send(1, 8'h34); send(1, 8'h12);
        idle(3);
        check("wide_count", wr_b.size(), 8);
        check("wide_ff", wr_at(1, 6), 32'h3FF);
        check("wide_trunc", wr_at(1, 7), 32'hA34);
        check("wide_no_err", errs_b, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_matrix_cfg.md
# uart_matrix_cfg

Configuration sequencer for `uart_matrix`. It drives the matrix routing-LUT write port (`lut_data`/`lut_addr`/`lut_cke`), and has two jobs:
- After every reset, it bulk-loads a default routing table into the LUT.
- After that, it applies runtime routing updates parsed from a byte stream delivered as `cmd_data` with a `cmd_cke` strobe, as produced by a UART receiver.

It sits between a control-channel UART receiver and the matrix LUT port, and it is the only writer of that port.

## Interface
- `INPUTS`, default 2: number of matrix rx channels, equal to the number of LUT entries.
- `OUTPUTS`, default 3: number of matrix tx channels, equal to the LUT entry width.
- `INIT`, default all-ones, `INPUTS*OUTPUTS` bits: default table. Entry i is `INIT[i*OUTPUTS +: OUTPUTS]`, so the last item of a concatenation is entry 0.
- `TIMEOUT`, default 1000: maximum allowed gap, in clk cycles, between bytes of one frame.
- Derived, not overridable:
  - AW = max(1, clog2(INPUTS)).
  - NB = ceil(OUTPUTS/8).

Ports:
- `clk` in 1: sole clock. All logic is on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `cmd_data` in 8: command byte. Valid only while `cmd_cke`=1.
- `cmd_cke` in 1: one-cycle strobe, one per received byte.
- `lut_data` out OUTPUTS: LUT entry value (tx enable mask).
- `lut_addr` out AW: LUT entry index (rx channel).
- `lut_cke` out 1: one-cycle LUT write strobe.
- `busy` out 1: high while the default load is in progress.
- `err` out 1: one-cycle error pulse.

## Operation
- **States:** LOAD, SYNC, ADDR, MASK, COMMIT.
- **Frame format:** 0xA5, then one address byte, then NB mask bytes, least-significant byte first. Mask bits at positions ≥OUTPUTS are discarded.
- **LOAD:**
  - Entered on `rst` and when a frame carrying address 0xFF commits.
  - Writes entries 0..INPUTS-1 in ascending order, one per cycle. `lut_cke`=1 on every LOAD cycle, with `lut_data` set to the INIT entry.
  - After entry INPUTS-1 is written, the next state is SYNC.
  - `busy`=1 for the whole of LOAD.
  - Any `cmd_cke` during LOAD drops the byte and pulses `err`.
- **SYNC:**
  - 0xA5 moves to ADDR.
  - Any other byte is ignored silently, with no `err`.
- **ADDR:** stores the byte and moves to MASK. The byte counter resets to 0.
- **MASK:** stores each byte in its slot. When the NBth byte is stored, the next state is COMMIT.
- **COMMIT:** a single cycle, then SYNC.
  - If addr < INPUTS: one LUT write.
  - If addr = 0xFF: go to LOAD instead of SYNC, with no write in the COMMIT cycle.
  - Any other address: no write, `err` pulse.
  - A `cmd_cke` arriving in COMMIT is processed as if in SYNC.
- **Timeout:**
  - The gap counter runs in ADDR and MASK and is cleared by every `cmd_cke`.
  - When it reaches TIMEOUT without a byte, the frame is discarded, `err` pulses, and the next state is SYNC.
  - Any byte arriving in that same cycle is discarded.
- **Reset:** `rst` has priority over everything, including mid-frame and mid-LOAD. A partial frame is lost and LOAD restarts from entry 0.

## Timing
- **Output values during `rst`=1:** `lut_cke`=0, `lut_addr`=0, `lut_data`=0, `busy`=1, `err`=0.
- **Default load:**
  - The first cycle after `rst` falls is the first LOAD cycle: `lut_cke`=1, `lut_addr`=0, `lut_data`=INIT entry 0.
  - LOAD lasts exactly INPUTS cycles.
  - `busy` falls in the cycle after the last write.
  - The first byte accepted is the one strobed on that cycle or later.
- **Runtime write latency:** the `lut_cke` pulse comes exactly 1 cycle after the cycle in which the last mask byte is strobed.
- **Write-port signals:**
  - `lut_data`/`lut_addr` are registered and change only in a cycle where `lut_cke`=1.
  - Between writes they hold their last value.
- **`err` timing:** `err` is registered and appears 1 cycle after the triggering event.
- **Back-to-back bytes:** `cmd_cke` may be high on consecutive cycles, and every byte is consumed. Back-to-back frames need no idle cycles.

## Test plan
- **Default load** (INPUTS=2, OUTPUTS=3, INIT={3'b001,3'b111}): release `rst` → `lut_cke` is high for 2 cycles with (addr 0, data 111) then (addr 1, data 001); `busy` falls on the next cycle; no `err`.
- **Runtime update:** send bytes A5,01,05 back-to-back → a single write pulse 1 cycle after the 05 byte with addr 1, data 101; `err` stays low.
- **Errors and junk:**
  - Send 3C, then A5,07,02 → 3C produces no response; the frame produces no write and an `err` pulse 1 cycle after COMMIT.
  - Send A5,01 and then wait TIMEOUT cycles → `err` pulses and there is no write; a following A5,00,06 writes addr 0, data 110.
- **Reload and bytes during LOAD:**
  - Send A5,FF,00 → `busy` rises and both INIT entries are rewritten in 2 cycles.
  - A byte strobed during that LOAD → `err` pulses and the byte is dropped.
- **Reset mid-frame:** assert `rst` for 1 cycle after A5,01 → on release LOAD restarts at addr 0; the stale frame never commits.
- **Wide mask** (OUTPUTS=10, NB=2): send A5,00,FF,FF → write data 10'h3FF; the upper 6 bits of the second byte are ignored.
